// File: rtl/irq_latch16_pkg.sv
// Shared types and helpers for the 16-line interrupt latch.
// Latency: none (declarations only).
// Backpressure: not applicable.
package irq_latch16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Index of the highest set bit; 0 when nothing is set.
    // Ascending scan so the last (highest) match wins.
    function automatic logic [IDX_W-1:0] hi_bit(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                r = i[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_latch16_sync_edge.sv
// Multi-bit synchronizer followed by a rising-edge detector.
// Latency: rise is valid SYNC_STAGES-1 edges after the first edge sampling din high.
// Backpressure: none; rise is a single-cycle pulse per detected edge.
module sync_edge #(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] dly_q;

    // Synchronizer chain plus one-cycle-delayed copy of the last stage.
    // Resetting dly_q to 0 makes a line held high across reset look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/irq_latch16.sv
// Latches 16 async request edges and presents them one at a time, highest index first.
// Latency: vld rises SYNC_STAGES+1 edges after req is first sampled high (from idle).
// Backpressure: idx/vld hold until ack; optional mask port under IRQ_LATCH16_MASK_EN.
module irq_latch16
    import irq_latch16_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
`ifdef IRQ_LATCH16_MASK_EN
    input  logic [N_REQ-1:0] mask,
`endif
    output logic             vld,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] pend,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] elig;
    logic             ovf_q, ovf_d;

    sync_edge #(
        .W           (N_REQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (req),
        .rise  (rise)
    );

    // Masked bits still latch; they are only hidden from selection in IDLE.
`ifdef IRQ_LATCH16_MASK_EN
    assign elig = pend_q & ~mask;
`else
    assign elig = pend_q;
`endif

    // Grant FSM: pick highest eligible bit in IDLE, hold it in PRESENT until ack.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (|elig) begin
                    state_d = ST_PRESENT;
                    idx_d   = hi_bit(elig);
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    clr     = N_REQ'(1) << idx_q;
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Pending bits: a fresh edge wins over a same-cycle clear; an edge on an
    // already-pending bit that is not being cleared is an overflow.
    always_comb begin
        pend_d = (pend_q & ~clr) | rise;
        ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
    end

    // State, presented index, pending bits and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign vld  = (state_q == ST_PRESENT);
    assign idx  = idx_q;
    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_irq_latch16.sv
// Directed bench for irq_latch16 (mask scenario only when IRQ_LATCH16_MASK_EN is defined).
// Latency: checks sample 1 time unit after rising edges.
// Backpressure: ack driven directly by the stimulus sequence.
module tb_irq_latch16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        ack;
`ifdef IRQ_LATCH16_MASK_EN
    logic [15:0] mask;
`endif
    logic        vld;
    logic [3:0]  idx;
    logic [15:0] pend;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    irq_latch16 #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ack   (ack),
`ifdef IRQ_LATCH16_MASK_EN
        .mask  (mask),
`endif
        .vld   (vld),
        .idx   (idx),
        .pend  (pend),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
`ifdef IRQ_LATCH16_MASK_EN
        mask  = '0;
`endif
        step(2);
        check("rst_vld",  32'(vld),  32'h0);
        check("rst_idx",  32'(idx),  32'h0);
        check("rst_pend", 32'(pend), 32'h0);
        check("rst_ovf",  32'(ovf),  32'h0);
        rst_n = 1'b1;
        step(2);

        // Single request on bit 0, ack held low.
        req = 16'h0001;
        step(1);                                  // sampling edge
        req = 16'h0000;
        check("a_vld_e0", 32'(vld), 32'h0);
        step(1);
        check("a_pend_e1", 32'(pend), 32'h0);
        step(1);
        check("a_pend_e2", 32'(pend), 32'h0001);
        check("a_vld_e2",  32'(vld),  32'h0);
        step(1);
        check("a_vld_e3",  32'(vld),  32'h1);
        check("a_idx_e3",  32'(idx),  32'h0);
        step(3);
        check("a_vld_hold",  32'(vld),  32'h1);
        check("a_pend_hold", 32'(pend), 32'h0001);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("a_vld_ack",  32'(vld),  32'h0);
        check("a_pend_ack", 32'(pend), 32'h0);

        // Four simultaneous edges, ack held high: 15, 10, 5, 0.
        req = 16'h8421;
        ack = 1'b1;
        step(3);
        check("b_pend", 32'(pend), 32'h8421);
        check("b_vld0", 32'(vld),  32'h0);
        step(1);
        check("b_g15_vld", 32'(vld), 32'h1);
        check("b_g15_idx", 32'(idx), 32'd15);
        step(1);
        check("b_gap1_vld", 32'(vld), 32'h0);
        check("b_gap1_idx", 32'(idx), 32'h0);
        check("b_gap1_pend", 32'(pend), 32'h0421);
        step(1);
        check("b_g10_idx", 32'(idx), 32'd10);
        check("b_g10_vld", 32'(vld), 32'h1);
        step(1);
        check("b_gap2_vld", 32'(vld), 32'h0);
        step(1);
        check("b_g5_idx", 32'(idx), 32'd5);
        check("b_g5_vld", 32'(vld), 32'h1);
        step(1);
        check("b_gap3_vld", 32'(vld), 32'h0);
        step(1);
        check("b_g0_idx", 32'(idx), 32'd0);
        check("b_g0_vld", 32'(vld), 32'h1);
        step(1);
        check("b_end_vld",  32'(vld),  32'h0);
        check("b_end_pend", 32'(pend), 32'h0);
        check("b_ovf",      32'(ovf),  32'h0);
        ack = 1'b0;
        req = '0;
        step(3);

        // Higher-priority bit arrives while bit 3 is presented.
        req = 16'h0008;
        step(4);
        check("c_idx3", 32'(idx), 32'd3);
        req = 16'h1008;
        step(4);
        check("c_pend",     32'(pend), 32'h1008);
        check("c_vld_hold", 32'(vld),  32'h1);
        check("c_idx_hold", 32'(idx),  32'd3);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("c_pend_ack", 32'(pend), 32'h1000);
        step(1);
        check("c_idx12", 32'(idx), 32'd12);
        check("c_vld12", 32'(vld), 32'h1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        req = '0;
        step(3);

        // Overflow: second edge on bit 7 while still pending.
        req = 16'h0080;
        step(4);
        check("d_idx7", 32'(idx), 32'd7);
        check("d_ovf0", 32'(ovf), 32'h0);
        req = '0;
        step(3);
        req = 16'h0080;
        step(3);
        check("d_ovf1", 32'(ovf), 32'h1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        req = '0;
        check("d_pend_ack", 32'(pend), 32'h0);
        step(3);
        check("d_ovf_sticky", 32'(ovf), 32'h1);
        rst_n = 1'b0;
        #1;
        check("d_ovf_rst", 32'(ovf), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Edge on bit 5 coincides with the ack clearing pend[5].
        req = 16'h0020;
        step(4);
        check("e_idx5", 32'(idx), 32'd5);
        req = '0;
        step(3);
        req = 16'h0020;
        step(2);                                  // rise now active for one cycle
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("e_pend_kept", 32'(pend), 32'h0020);
        check("e_vld_gap",   32'(vld),  32'h0);
        check("e_ovf",       32'(ovf),  32'h0);
        step(1);
        check("e_vld_re", 32'(vld), 32'h1);
        check("e_idx_re", 32'(idx), 32'd5);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        req = '0;
        check("e_pend_clr", 32'(pend), 32'h0);
        step(3);

        // Reset mid-grant, with the request still high across release.
        req = 16'h0004;
        step(4);
        check("f_idx2", 32'(idx), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("f_async_vld",  32'(vld),  32'h0);
        check("f_async_pend", 32'(pend), 32'h0);
        check("f_async_idx",  32'(idx),  32'h0);
        step(1);
        rst_n = 1'b1;
        step(1);                                  // sampling edge after release
        step(3);
        check("f_relaunch_vld", 32'(vld), 32'h1);
        check("f_relaunch_idx", 32'(idx), 32'd2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        req = '0;
        step(3);

`ifdef IRQ_LATCH16_MASK_EN
        // Masked bit 1 latches but is skipped until the mask clears.
        mask = 16'h0002;
        req  = 16'h0003;
        step(4);
        check("g_pend", 32'(pend), 32'h0003);
        check("g_idx0", 32'(idx),  32'd0);
        check("g_vld0", 32'(vld),  32'h1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);
        check("g_masked_vld", 32'(vld),  32'h0);
        check("g_masked_pnd", 32'(pend), 32'h0002);
        mask = 16'h0000;
        step(1);
        check("g_idx1", 32'(idx), 32'd1);
        check("g_vld1", 32'(vld), 32'h1);
        mask = 16'h0002;
        step(2);
        check("g_keep_vld", 32'(vld), 32'h1);
        check("g_keep_idx", 32'(idx), 32'd1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        req = '0;
        mask = '0;
        check("g_end_pend", 32'(pend), 32'h0);
        step(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_latch16.md
IRQ_LATCH16 -- requirements
Module: irq_latch16

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per request line; legal range 2..3.
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  16  asynchronous request lines; bit 15 highest priority.
REQ-005 SHALL have port ack  input  1  consumer accepts the presented index.
REQ-006 SHALL have port vld  output  1  an index is presented.
REQ-007 SHALL have port idx  output  4  presented request number, 0..15.
REQ-008 SHALL have port pend  output  16  pending-bit register, direct flop outputs.
REQ-009 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-010 SHALL synchronize each req bit through SYNC_STAGES flops, then detect a rising edge as last stage high and a one-cycle-delayed copy low.
REQ-011 SHALL set pend[i] on the clock edge after a rising edge on bit i is detected.
REQ-012 SHALL assert vld SYNC_STAGES+1 clock edges after the first edge sampling req[i] high, when starting from IDLE with no other pending bits (3 edges at default).
REQ-013 SHALL implement FSM states IDLE (vld=0) and PRESENT (vld=1).
REQ-014 IDLE->PRESENT when any pend bit is set: idx registers the highest set pend bit.
REQ-015 In PRESENT, idx and vld SHALL hold stable until ack, even if higher-priority bits become pending.
REQ-016 PRESENT with ack=1 at a clock edge SHALL clear pend[idx] and return to IDLE on that edge, giving vld low for exactly one cycle between back-to-back grants.
REQ-017 ack while vld=0 SHALL be ignored.
REQ-018 An edge on bit i in the same cycle that the ack clears pend[i] SHALL leave pend[i]=1; set wins.
REQ-019 An edge on bit i while pend[i] is already 1, and not being cleared in that cycle, SHALL set ovf; ovf clears only on reset.
REQ-020 Simultaneous edges on several bits SHALL set all of the corresponding pend bits in one cycle; grants then follow descending index order.
REQ-021 idx SHALL read 0 whenever vld=0.

Reset
REQ-022 rst_n low SHALL immediately, without a clock, force the FSM to IDLE, vld=0, idx=0, pend=0, ovf=0 and all synchronizer and edge flops to 0.
REQ-023 A req bit that is high when rst_n is released SHALL be treated as a rising edge.
REQ-024 Reset asserted mid-grant SHALL discard the grant; no ack is required afterwards.

Configuration
REQ-025 Macro IRQ_LATCH16_MASK_EN defined: a port mask input 16 SHALL exist, and pend bits with mask[i]=1 SHALL still latch but SHALL be excluded from selection in IDLE.
REQ-026 With IRQ_LATCH16_MASK_EN defined, masking the currently presented bit SHALL NOT withdraw vld.
REQ-027 Macro undefined: no mask port SHALL exist, and all pend bits SHALL be eligible.

Structure
REQ-028 Package irq_latch16_pkg SHALL hold N_REQ=16, IDX_W=4, the FSM state typedef and the highest-set-bit selection function.
REQ-029 A sub-module sync_edge (width parameter, SYNC_STAGES parameter) SHALL contain the synchronizer and rising-edge detector; it is instantiated once, 16 wide.

Verification
REQ-030 Bench SHALL cover: req=16'h0001 pulse from reset, ack held 0 -> vld=1, idx=0 on the 3rd edge after sampling; pend=16'h0001; both hold stable.
REQ-031 Bench SHALL cover: req 16'h0000->16'h8421 in one cycle, ack held 1 -> idx sequence 15, 10, 5, 0 with vld low for one cycle between each grant; pend ends at 0.
REQ-032 Bench SHALL cover: bit 3 presented, then bit 12 edge arrives before ack -> idx stays 3 until ack; next grant is idx=12.
REQ-033 Bench SHALL cover: second edge on bit 7 while pend[7]=1 -> ovf=1, which persists across later acks until rst_n low.
REQ-034 Bench SHALL cover: edge on bit 5 in the same cycle as ack of idx 5 -> pend[5] stays 1 and vld reasserts with idx=5 one cycle later.
REQ-035 Bench SHALL cover, with IRQ_LATCH16_MASK_EN defined: mask=16'h0002, edges on bits 1 and 0 -> only idx=0 is granted; clearing the mask then grants idx=1.
